// File: rtl/sram_bank.sv
// ============================================================================
// Module   : sram_bank
// Purpose  : Single-port synchronous RAM bank with clear sequencer, req/ready
//            handshake, registered read strobe and selectable read-during-write.
//            Optional build macro: SRAM_PARITY_EN (per-word even parity).
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_bank #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  clr,
    output logic                  ready,
    output logic                  busy,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  parity_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef SRAM_PARITY_EN
    localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int MEM_WIDTH = DATA_WIDTH;
`endif

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [MEM_WIDTH-1:0]    mem_q [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [MEM_WIDTH-1:0]    mem_wword;
    logic [MEM_WIDTH-1:0]    mem_rword;
    logic                    acc_rd;
    logic                    acc_wr;

    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    perr_q, perr_d;
    logic                    perr_now;

    // Stored word layout: {parity, data} when parity is enabled.
    function automatic logic [MEM_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
`ifdef SRAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    assign mem_rword = mem_q[addr];
    assign ready     = (state_q == S_IDLE);
    assign busy      = (state_q == S_CLEAR);

`ifdef SRAM_PARITY_EN
    assign perr_now  = ^mem_rword;
`else
    assign perr_now  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wword = encode(wdata);
        acc_rd    = 1'b0;
        acc_wr    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wword = encode(INIT_VALUE);
                cnt_d     = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                // A clear request pre-empts any access presented on the same edge.
                if (clr) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (req) begin
                    acc_rd = ~we;
                    acc_wr = we;
                    mem_we = we;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wword;
        end
    end

    always_comb begin
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        perr_d   = 1'b0;
        if (acc_rd || (acc_wr && (RDW_MODE != 0))) begin
            rvalid_d = 1'b1;
            rdata_d  = mem_rword[DATA_WIDTH-1:0];
            perr_d   = perr_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            perr_q   <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            perr_q   <= perr_d;
        end
    end

    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign parity_err = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_bank.sv
// ============================================================================
// Module   : tb_sram_bank
// Purpose  : Directed self-checking bench for sram_bank (RDW_MODE 0 and 1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_bank;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam logic [DW-1:0] INIT = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          clr;

    logic          ready0, busy0, rvalid0, perr0;
    logic [DW-1:0] rdata0;
    logic          ready1, busy1, rvalid1, perr1;
    logic [DW-1:0] rdata1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INIT), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .clr(clr),
        .ready(ready0), .busy(busy0), .rvalid(rvalid0), .rdata(rdata0), .parity_err(perr0)
    );

    sram_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INIT), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .clr(clr),
        .ready(ready1), .busy(busy1), .rvalid(rvalid1), .rdata(rdata1), .parity_err(perr1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic c);
        req = r; we = w; addr = a; wdata = d; clr = c;
    endtask

    // After a clear-starting edge, ready must stay low until the 16th further edge.
    task automatic sweep(input string tag);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i < 16) chk(tag, {ready0, busy0, rvalid0}, 3'b010);
            else        chk(tag, {ready0, busy0, rvalid0}, 3'b100);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        tick();
        chk("reset_state", {ready0, busy0, rvalid0, rdata0, perr0}, {3'b010, 8'h00, 1'b0});

        // Requests during the sweep must be ignored (addr 0 stays INIT).
        rst = 1'b0;
        drive(1'b1, 1'b1, 4'd0, 8'hFF, 1'b0);
        sweep("reset_sweep");
        drive(1'b0, 1'b0, '0, '0, 1'b0);

        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b0, a[AW-1:0], 8'h00, 1'b0);
            tick();
            chk("init_read", {rvalid0, rdata0, perr0}, {1'b1, INIT, 1'b0});
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        chk("idle_hold", {rvalid0, rdata0}, {1'b0, INIT});

        drive(1'b1, 1'b1, 4'd5, 8'h3C, 1'b0);
        tick();
        chk("wr_rdw0", {rvalid0, rdata0}, {1'b0, INIT});
        chk("wr_rdw1", {rvalid1, rdata1}, {1'b1, INIT});
        drive(1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
        tick();
        chk("wr_then_rd", {rvalid0, rdata0}, {1'b1, 8'h3C});
        drive(1'b1, 1'b0, 4'd6, 8'h00, 1'b0);
        tick();
        chk("b2b_rd6", {rvalid0, rdata0}, {1'b1, INIT});

        drive(1'b1, 1'b1, 4'd2, 8'h11, 1'b0);
        tick();
        drive(1'b1, 1'b1, 4'd2, 8'h22, 1'b0);
        tick();
        chk("rdw1_old", {rvalid1, rdata1}, {1'b1, 8'h11});
        chk("rdw0_none", rvalid0, 1'b0);
        drive(1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
        tick();
        chk("rdw_newrd0", {rvalid0, rdata0}, {1'b1, 8'h22});
        chk("rdw_newrd1", {rvalid1, rdata1}, {1'b1, 8'h22});

        // clr collides with a write: clr wins, write to addr 3 is dropped.
        drive(1'b1, 1'b1, 4'd3, 8'hFF, 1'b1);
        tick();
        chk("clr_edge", {ready0, busy0, rvalid0}, 3'b010);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        sweep("clr_sweep");
        drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
        tick();
        chk("clr_addr3", {rvalid0, rdata0}, {1'b1, INIT});
        drive(1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
        tick();
        chk("clr_addr2", {rvalid1, rdata1}, {1'b1, INIT});

        // Reset seven cycles into a sweep restarts it from address 0.
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst", {ready0, busy0, rvalid0, rdata0}, {3'b010, 8'h00});
        rst = 1'b0;
        sweep("mid_rst_sweep");

        // Reset while rvalid is high clears it on that edge.
        drive(1'b1, 1'b0, 4'd9, 8'h00, 1'b0);
        tick();
        chk("pre_rst_rd", {rvalid0, rdata0}, {1'b1, INIT});
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        tick();
        chk("rst_rvalid", {rvalid0, rdata0, ready0}, {1'b0, 8'h00, 1'b0});
        rst = 1'b0;
        sweep("final_sweep");

`ifdef SRAM_PARITY_EN
        drive(1'b1, 1'b1, 4'd7, 8'h01, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        dut0.mem_q[7] = 9'h100;
        drive(1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
        tick();
        chk("par_err", {rvalid0, perr0}, 2'b11);
        drive(1'b1, 1'b0, 4'd8, 8'h00, 1'b0);
        tick();
        chk("par_ok", {rvalid0, perr0}, 2'b10);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        chk("par_idle", {rvalid0, perr0}, 2'b00);
`else
        drive(1'b1, 1'b1, 4'd7, 8'h01, 1'b0);
        tick();
        drive(1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
        tick();
        chk("nopar_rd", {rvalid0, rdata0, perr0, perr1}, {1'b1, 8'h01, 2'b00});
        drive(1'b0, 1'b0, '0, '0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
